// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: cpu fetch/data request ports, shared memory bus and status.
// The arbiter connects through the slave modport; requesters and memory model use master.
interface mem_arbiter_if #(
   parameter int XLEN = 32
);
   logic            if_req;
   logic [XLEN-1:0] if_addr;
   logic [XLEN-1:0] if_rdata;
   logic            if_ack;
   logic            d_req;
   logic            d_we;
   logic [XLEN-1:0] d_addr;
   logic [XLEN-1:0] d_wdata;
   logic [XLEN-1:0] d_rdata;
   logic            d_ack;
   logic            m_req;
   logic            m_we;
   logic [XLEN-1:0] m_addr;
   logic [XLEN-1:0] m_wdata;
   logic [XLEN-1:0] m_rdata;
   logic            m_ack;
   logic            if_stall;
   logic            d_stall;
   logic            err;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
      output if_rdata, if_ack, d_rdata, d_ack, m_req, m_we, m_addr, m_wdata,
             if_stall, d_stall, err
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
      input  if_rdata, if_ack, d_rdata, d_ack, m_req, m_we, m_addr, m_wdata,
             if_stall, d_stall, err
   );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data ports onto one req/ack memory bus; data wins, bounded by a burst counter.
// Optional abort of stuck bus transactions when MEM_ARB_TIMEOUT_EN is defined (sticky err).
module mem_arbiter #(
   parameter int XLEN        = 32,
   parameter int MAX_D_BURST = 4,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic           clock,
   input  logic           reset,
   mem_arbiter_if.slave   bus
);
   typedef enum logic [1:0] {IDLE, GRANT_D, GRANT_I} state_t;

   localparam int             BW    = $clog2(MAX_D_BURST + 1);
   localparam logic [BW-1:0]  MAX_B = BW'(MAX_D_BURST);

   state_t          state_q, state_d;
   logic [BW-1:0]   burst_q, burst_d;
   logic            m_req_q, m_req_d;
   logic            m_we_q, m_we_d;
   logic [XLEN-1:0] m_addr_q, m_addr_d;
   logic [XLEN-1:0] m_wdata_q, m_wdata_d;
   logic [XLEN-1:0] if_rdata_q, if_rdata_d;
   logic [XLEN-1:0] d_rdata_q, d_rdata_d;
   logic            if_ack_q, if_ack_d;
   logic            d_ack_q, d_ack_d;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int            TW      = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic          err_q, err_d;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         burst_q    <= '0;
         m_req_q    <= 1'b0;
         m_we_q     <= 1'b0;
         m_addr_q   <= '0;
         m_wdata_q  <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
         if_ack_q   <= 1'b0;
         d_ack_q    <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
         to_cnt_q   <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         burst_q    <= burst_d;
         m_req_q    <= m_req_d;
         m_we_q     <= m_we_d;
         m_addr_q   <= m_addr_d;
         m_wdata_q  <= m_wdata_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
         if_ack_q   <= if_ack_d;
         d_ack_q    <= d_ack_d;
`ifdef MEM_ARB_TIMEOUT_EN
         to_cnt_q   <= to_cnt_d;
         err_q      <= err_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      burst_d    = burst_q;
      m_req_d    = m_req_q;
      m_we_d     = m_we_q;
      m_addr_d   = m_addr_q;
      m_wdata_d  = m_wdata_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      if_ack_d   = 1'b0;
      d_ack_d    = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      to_cnt_d   = to_cnt_q;
      err_d      = err_q;
`endif
      case (state_q)
         IDLE: begin
`ifdef MEM_ARB_TIMEOUT_EN
            to_cnt_d = '0;
`endif
            if (!bus.if_req) burst_d = '0;
            // Requests still visible during an ack cycle are the requester's next access.
            if (bus.d_req && (!bus.if_req || burst_q < MAX_B)) begin
               state_d   = GRANT_D;
               m_req_d   = 1'b1;
               m_we_d    = bus.d_we;
               m_addr_d  = bus.d_addr;
               m_wdata_d = bus.d_wdata;
               if (bus.if_req) burst_d = burst_q + BW'(1);
            end else if (bus.if_req) begin
               state_d   = GRANT_I;
               m_req_d   = 1'b1;
               m_we_d    = 1'b0;
               m_addr_d  = bus.if_addr;
               m_wdata_d = '0;
               burst_d   = '0;
            end
         end
         GRANT_D, GRANT_I: begin
            if (bus.m_ack) begin
               state_d = IDLE;
               m_req_d = 1'b0;
               if (state_q == GRANT_D) begin
                  d_ack_d = 1'b1;
                  // Stores leave the load-data register untouched.
                  if (!m_we_q) d_rdata_d = bus.m_rdata;
               end else begin
                  if_ack_d   = 1'b1;
                  if_rdata_d = bus.m_rdata;
               end
`ifdef MEM_ARB_TIMEOUT_EN
            end else if (to_cnt_q == TO_LAST) begin
               state_d = IDLE;
               m_req_d = 1'b0;
               err_d   = 1'b1;
               if (state_q == GRANT_D) begin
                  d_ack_d   = 1'b1;
                  d_rdata_d = '0;
               end else begin
                  if_ack_d   = 1'b1;
                  if_rdata_d = '0;
               end
            end else begin
               to_cnt_d = to_cnt_q + TW'(1);
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.m_req    = m_req_q;
   assign bus.m_we     = m_we_q;
   assign bus.m_addr   = m_addr_q;
   assign bus.m_wdata  = m_wdata_q;
   assign bus.if_rdata = if_rdata_q;
   assign bus.d_rdata  = d_rdata_q;
   assign bus.if_ack   = if_ack_q;
   assign bus.d_ack    = d_ack_q;
   assign bus.if_stall = bus.if_req & ~if_ack_q;
   assign bus.d_stall  = bus.d_req & ~d_ack_q;
`ifdef MEM_ARB_TIMEOUT_EN
   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif
endmodule
